// File: rtl/tstate_sequencer.sv
// One-hot T-state generator with early termination, boundary halt and an instruction-done pulse.
// Optional single-step operation is enabled by defining SEQ_SINGLE_STEP_EN.
//
// state  | meaning
// RUN    | stepping through T-states 0..STATES-1; fetch, increment, decode, then execute steps
// HALTED | parked at an instruction boundary; all strobes low, resumes at fetch when halt drops
module tstate_sequencer #(
    parameter int STATES = 6,
    parameter int STEP_W = $clog2(STATES)
) (
    input  logic              clock,
    input  logic              input_clear,
    input  logic              input_clock_enable,
    input  logic              input_end_early,
    input  logic              input_halt,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic              input_step_mode,
    input  logic              input_step,
`endif
    output logic [STATES-1:0] output_tstate,
    output logic [STEP_W-1:0] output_step,
    output logic              output_fetch,
    output logic              output_increment,
    output logic              output_decode,
    output logic              output_execute,
    output logic              output_instr_done,
    output logic              output_halted
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } mode_t;

    localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(STATES - 1);
    localparam logic [STEP_W-1:0] EXEC_FIRST = STEP_W'(3);

    mode_t             mode, mode_nxt;
    logic [STEP_W-1:0] step, step_nxt;
    logic              done_r, done_nxt;
    logic              advance;
    logic              boundary;

`ifdef SEQ_SINGLE_STEP_EN
    logic step_prev;

    always_ff @(posedge clock) begin
        if (input_clear) begin
            step_prev <= 1'b0;
        end else begin
            step_prev <= input_step;
        end
    end

    // In single-step mode only the rising edge of the button counts as an enabled cycle.
    assign advance = input_clock_enable && (!input_step_mode || (input_step && !step_prev));
`else
    assign advance = input_clock_enable;
`endif

    // End-early is only meaningful once the execute steps have started.
    assign boundary = (step == LAST_STEP) || (input_end_early && (step >= EXEC_FIRST));

    always_ff @(posedge clock) begin
        if (input_clear) begin
            step   <= '0;
            mode   <= RUN;
            done_r <= 1'b0;
        end else begin
            step   <= step_nxt;
            mode   <= mode_nxt;
            done_r <= done_nxt;
        end
    end

    always_comb begin
        step_nxt = step;
        mode_nxt = mode;
        done_nxt = done_r;
        if (advance) begin
            case (mode)
                RUN: begin
                    if (boundary) begin
                        step_nxt = '0;
                        done_nxt = 1'b1;
                        if (input_halt) begin
                            mode_nxt = HALTED;
                        end
                    end else begin
                        step_nxt = step + STEP_W'(1);
                        done_nxt = 1'b0;
                    end
                end
                HALTED: begin
                    step_nxt = '0;
                    done_nxt = 1'b0;
                    if (!input_halt) begin
                        mode_nxt = RUN;
                    end
                end
                default: begin
                    step_nxt = '0;
                    mode_nxt = RUN;
                    done_nxt = 1'b0;
                end
            endcase
        end
    end

    assign output_tstate     = (mode == RUN) ? (STATES'(1) << step) : '0;
    assign output_step       = (mode == RUN) ? step : '0;
    assign output_fetch      = (mode == RUN) && (step == STEP_W'(0));
    assign output_increment  = (mode == RUN) && (step == STEP_W'(1));
    assign output_decode     = (mode == RUN) && (step == STEP_W'(2));
    assign output_execute    = (mode == RUN) && (step >= EXEC_FIRST);
    assign output_instr_done = done_r;
    assign output_halted     = (mode == HALTED);

endmodule
